telemetry_ascii_decoder: RTL and testbench

Parses a stream of ASCII characters into fixed-width telemetry values. It is the inverse of the on-screen telemetry digit encoder. Each line has the form "<idx>=<digits><term>" and updates one entry of a register bank. The bank drives telemetry_values of the overlay, or game control registers. Character source is a valid/ready byte stream, normally the UART RX block.

---
 rtl/telemetry_ascii_decoder.sv | 126 ++++++++++++
 tb/tb_telemetry_ascii_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_ascii_decoder.sv
// rtl/telemetry_ascii_decoder.sv - parses "<idx>=<digits><term>" ASCII lines into a bank of value registers
module telemetry_ascii_decoder #(
  parameter int NUM_SIGNALS = 7,
  parameter int VALUE_WIDTH = 9,
  parameter int BASE        = 10,
  localparam int IDX_W      = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic [VALUE_WIDTH-1:0] values_out [NUM_SIGNALS],
  output logic                   update_valid,
  output logic [IDX_W-1:0]       update_idx,
  output logic                   error_pulse
);

  function automatic int calc_max_digits();
    longint p = 1;
    int     n = 0;
    for (int i = 0; i < 64; i++) begin
      if (p < (longint'(1) << VALUE_WIDTH)) begin
        p = p * BASE;
        n++;
      end
    end
    return n;
  endfunction

  localparam int MAX_DIGITS = calc_max_digits();
  localparam int ACC_W      = VALUE_WIDTH + 6;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((longint'(1) << VALUE_WIDTH) - 1);

  // Letters map to 10..35 regardless of BASE; 63 marks a non-digit.
  function automatic logic [5:0] char_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 6'(c - "0");
    if (c >= "A" && c <= "Z") return 6'(c - "A" + 8'd10);
    if (c >= "a" && c <= "z") return 6'(c - "a" + 8'd10);
    return 6'd63;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_EQ, S_DIGITS, S_COMMIT, S_DRAIN} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  logic [5:0]       dig;
  logic             is_term;
  logic             dig_ok;
  logic [ACC_W-1:0] new_acc;
  logic             bad;

  assign char_ready = (state != S_COMMIT);

  always_comb begin
    dig     = char_val(char_in);
    is_term = (char_in == 8'h0D) || (char_in == 8'h0A);
    dig_ok  = int'(dig) < BASE;
    new_acc = acc * ACC_W'(BASE) + ACC_W'(dig);
    bad     = 1'b0;
    case (state)
      S_IDLE:   bad = !is_term && !(int'(dig) < NUM_SIGNALS);
      S_EQ:     bad = (char_in != "=");
      S_DIGITS: begin
        if (is_term)     bad = (cnt == '0);
        else if (dig_ok) bad = (cnt == CNT_W'(MAX_DIGITS)) || (new_acc > MAX_VAL);
        else             bad = 1'b1;
      end
      default:  bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      idx          <= '0;
      update_valid <= 1'b0;
      update_idx   <= '0;
      error_pulse  <= 1'b0;
      for (int i = 0; i < NUM_SIGNALS; i++) values_out[i] <= '0;
    end else begin
      update_valid <= 1'b0;
      error_pulse  <= 1'b0;
      if (state == S_COMMIT) begin
        values_out[idx] <= acc[VALUE_WIDTH-1:0];
        update_idx      <= idx;
        update_valid    <= 1'b1;
        state           <= S_IDLE;
      end else if (char_valid) begin
        if (bad) begin
          error_pulse <= 1'b1;
          state       <= is_term ? S_IDLE : S_DRAIN;
        end else begin
          case (state)
            S_IDLE: if (!is_term) begin
              idx   <= dig[IDX_W-1:0];
              state <= S_EQ;
            end
            S_EQ: begin
              acc   <= '0;
              cnt   <= '0;
              state <= S_DIGITS;
            end
            S_DIGITS: begin
              if (is_term) begin
                state <= S_COMMIT;
              end else begin
                acc <= new_acc;
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_DRAIN: if (is_term) state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_telemetry_ascii_decoder.sv
// tb/tb_telemetry_ascii_decoder.sv - scoreboard bench for telemetry_ascii_decoder (BASE 10 and BASE 16 instances)
module tb_telemetry_ascii_decoder;

  localparam int NS = 7;
  localparam int VW = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [7:0]    ci0 = 8'h00, ci1 = 8'h00;
  logic          cv0 = 1'b0, cv1 = 1'b0;
  logic          rdy0, rdy1, uv0, uv1, ep0, ep1;
  logic [2:0]    ui0, ui1;
  logic [VW-1:0] v0 [NS];
  logic [VW-1:0] v1 [NS];

  typedef struct {
    bit upd;
    int idx;
    int val;
    int stamp;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  model [2][NS];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  stalls = 0;

  telemetry_ascii_decoder #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW), .BASE(10)) dut10 (
    .clk(clk), .reset(reset), .char_in(ci0), .char_valid(cv0), .char_ready(rdy0),
    .values_out(v0), .update_valid(uv0), .update_idx(ui0), .error_pulse(ep0)
  );

  telemetry_ascii_decoder #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW), .BASE(16)) dut16 (
    .clk(clk), .reset(reset), .char_in(ci1), .char_valid(cv1), .char_ready(rdy1),
    .values_out(v1), .update_valid(uv1), .update_idx(ui1), .error_pulse(ep1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int val(input int s, input int i);
    return (s == 0) ? int'(v0[i]) : int'(v1[i]);
  endfunction

  task automatic check_event(input int s, input bit upd, input int uidx);
    ev_t e;
    int  sz;
    sz = (s == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("unexpected_event_dut%0d", s), 1, 0);
    end else begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("event_kind_dut%0d", s), int'(upd), int'(e.upd));
      chk($sformatf("event_cycle_dut%0d", s), cyc, e.stamp);
      if (upd && e.upd) begin
        chk($sformatf("update_idx_dut%0d", s), uidx, e.idx);
        chk($sformatf("update_value_dut%0d", s), val(s, e.idx), e.val);
        model[s][e.idx] = e.val;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (uv0 || ep0) check_event(0, uv0, int'(ui0));
      if (uv1 || ep1) check_event(1, uv1, int'(ui1));
    end
  end

  // exp marks each char: 'E' error expected on acceptance, 'U' update expected one cycle later.
  task automatic send(input int s, input string str, input string exp,
                      input int uidx = 0, input int uval = 0);
    for (int i = 0; i < str.len(); i++) begin
      int  waits;
      int  edge_n;
      bit  r;
      ev_t e;
      waits = 0;
      edge_n = 0;
      if (s == 0) begin ci0 = str[i]; cv0 = 1'b1; end
      else        begin ci1 = str[i]; cv1 = 1'b1; end
      do begin
        @(negedge clk);
        r = (s == 0) ? rdy0 : rdy1;
        edge_n = cyc + 1;
        if (!r) begin
          stalls++;
          waits++;
        end
        @(posedge clk);
        #1;
      end while (!r && waits < 20);
      if (!r) begin
        chk("accept_timeout", 0, 1);
        return;
      end
      if (exp[i] == "E" || exp[i] == "U") begin
        e.upd   = (exp[i] == "U");
        e.idx   = uidx;
        e.val   = uval;
        e.stamp = e.upd ? edge_n + 1 : edge_n;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    cv0 = 1'b0;
    cv1 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input int s);
    for (int i = 0; i < NS; i++)
      chk($sformatf("bank_dut%0d[%0d]", s, i), val(s, i), model[s][i]);
  endtask

  task automatic check_reset_outputs(input int s);
    chk($sformatf("rst_char_ready_dut%0d", s), (s == 0) ? int'(rdy0) : int'(rdy1), 1);
    chk($sformatf("rst_update_valid_dut%0d", s), (s == 0) ? int'(uv0) : int'(uv1), 0);
    chk($sformatf("rst_update_idx_dut%0d", s), (s == 0) ? int'(ui0) : int'(ui1), 0);
    chk($sformatf("rst_error_pulse_dut%0d", s), (s == 0) ? int'(ep0) : int'(ep1), 0);
    check_bank(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NS; i++) model[s][i] = 0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    idle(2);

    send(0, "3=511\n", ".....U", 3, 511);
    idle(4);
    check_bank(0);

    send(0, "3=512\n", "....E.");
    send(0, "3=0\n", "...U", 3, 0);
    idle(4);
    check_bank(0);

    send(0, "9=5\n", "E...");
    send(0, "2=\n", "..E");
    send(0, "1=0042\n", ".....E.");
    idle(4);
    check_bank(0);

    send(0, "\r\n6=7\r\n", ".....U.", 6, 7);
    idle(4);
    check_bank(0);

    stalls = 0;
    send(0, "0=1\n", "...U", 0, 1);
    send(0, "1=2\n", "...U", 1, 2);
    cv0 = 1'b0;
    @(negedge clk);
    chk("ready_low_in_commit", int'(rdy0), 0);
    @(negedge clk);
    chk("ready_high_after_commit", int'(rdy0), 1);
    chk("stall_count_back_to_back", stalls, 1);
    idle(4);
    check_bank(0);

    send(1, "0=1ff\n", ".....U", 0, 511);
    send(1, "1=200\n", "....E.");
    idle(4);
    check_bank(1);

    send(1, "5=12", "....");
    cv1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NS; i++) model[s][i] = 0;
    @(negedge clk);
    check_reset_outputs(1);
    check_reset_outputs(0);
    reset = 1'b0;
    idle(2);

    send(1, "5=3\n", "...U", 5, 3);
    idle(4);
    check_bank(1);
    check_bank(0);

    chk("queue_empty_dut0", q0.size(), 0);
    chk("queue_empty_dut1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
